// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer that turns byte-swapped RGB565 pixel pairs into packed 8-bit grayscale words.
// Build option GRAYSCALE_THRESHOLD_EN adds a threshold port that turns each output byte into 8'hFF or 8'h00.

module rgb565_grayscale (
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic [16:0] sum;
    logic [8:0]  scaled;

    // Halfword layout is {g[2:0], b[4:0], r[4:0], g[5:3]}.
    // Luma weights are near Rec.709, scaled by 256. Full white comes out slightly above 255, so the result is clamped.
    assign r      = pixel[7:3];
    assign g      = {pixel[2:0], pixel[15:13]};
    assign b      = pixel[12:8];
    assign sum    = 17'(r) * 17'd448 + 17'(g) * 17'd746 + 17'(b) * 17'd160;
    assign scaled = sum[16:8];
    assign gray   = scaled[8] ? 8'hFF : scaled[7:0];
endmodule

module grayscale_stream_ctrl #(
    parameter int LINE_PIXELS = 640,
    parameter int LINE_COUNT  = 480
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        enable,
    input  logic        frameStart,
    input  logic [31:0] pixelWord,
    input  logic        pixelValid,
    output logic        pixelReady,
    output logic [31:0] grayWord,
    output logic        grayValid,
    input  logic        grayReady,
    output logic        grayLast,
    output logic        busy,
    output logic        frameDone
`ifdef GRAYSCALE_THRESHOLD_EN
    ,
    input  logic [7:0]  threshold
`endif
);
    // state | meaning
    // IDLE  | waiting for frameStart while enable is high
    // LOW   | accepting the first word of a group; both gray bytes go into the holding register
    // HIGH  | accepting the second word of a group; a packed word is loaded into the output register
    // DRAIN | last word is loaded; waiting for the sink to take it

    localparam int WORDS = LINE_PIXELS * LINE_COUNT / 4;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    if ((LINE_PIXELS * LINE_COUNT) % 4 != 0) begin : g_bad_geometry
        $error("LINE_PIXELS*LINE_COUNT must be a multiple of 4");
    end

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] word_cnt;
    logic [15:0]   held;
    logic [7:0]    raw0;
    logic [7:0]    raw1;
    logic [7:0]    gray0;
    logic [7:0]    gray1;
    logic          accept;
    logic          out_taken;

    rgb565_grayscale u_conv0 (.pixel(pixelWord[15:0]),  .gray(raw0));
    rgb565_grayscale u_conv1 (.pixel(pixelWord[31:16]), .gray(raw1));

`ifdef GRAYSCALE_THRESHOLD_EN
    assign gray0 = (raw0 >= threshold) ? 8'hFF : 8'h00;
    assign gray1 = (raw1 >= threshold) ? 8'hFF : 8'h00;
`else
    assign gray0 = raw0;
    assign gray1 = raw1;
`endif

    // HIGH can take a new word in the same cycle the sink takes the current one.
    always_comb begin
        pixelReady = 1'b0;
        case (state)
            LOW:     pixelReady = 1'b1;
            HIGH:    pixelReady = !grayValid || grayReady;
            default: pixelReady = 1'b0;
        endcase
    end

    assign accept    = pixelValid && pixelReady;
    assign out_taken = grayValid && grayReady;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            held      <= '0;
            grayWord  <= '0;
            grayValid <= 1'b0;
            grayLast  <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (out_taken) begin
                grayValid <= 1'b0;
                grayLast  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (frameStart && enable) state <= LOW;
                end
                LOW: begin
                    if (accept) begin
                        held  <= {gray1, gray0};
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (accept) begin
                        grayWord  <= {gray1, gray0, held};
                        grayValid <= 1'b1;
                        grayLast  <= (word_cnt == LAST_WORD);
                        word_cnt  <= word_cnt + 1'b1;
                        state     <= (word_cnt == LAST_WORD) ? DRAIN : LOW;
                    end
                end
                DRAIN: begin
                    if (out_taken) begin
                        frameDone <= 1'b1;
                        word_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/grayscale_stream_ctrl.md
Name: grayscale_stream_ctrl

Overview:
- Sequences the combinational RGB565-to-grayscale converter (rgb565Grayscale) over a full camera frame.
- Accepts 32-bit words of two byte-swapped RGB565 pixels over a valid/ready stream and routes each pixel through a converter instance.
- Packs four 8-bit grayscale results into one 32-bit output word on a second valid/ready stream.
- Counts words per frame, flags the last word, and signals frame completion; sits between the camera interface and the frame-buffer DMA.

Parameters:
- LINE_PIXELS, 640, pixels per line.
- LINE_COUNT, 480, lines per frame; LINE_PIXELS*LINE_COUNT must be a multiple of 4 (elaboration error otherwise).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- nReset  in  1  synchronous, active-low reset.
- enable  in  1  allows a new frame to start.
- frameStart  in  1  single-cycle pulse that starts a frame.
- pixelWord  in  32  [15:0] is pixel 0, [31:16] is pixel 1; each halfword uses converter layout {g[2:0],b[4:0],r[4:0],g[5:3]}.
- pixelValid  in  1  pixelWord is valid.
- pixelReady  out  1  controller accepts pixelWord this cycle.
- grayWord  out  32  byte n = grayscale of pixel n of the group (bytes 0-1 from the first input word, bytes 2-3 from the second).
- grayValid  out  1  grayWord is valid.
- grayReady  in  1  sink accepts grayWord.
- grayLast  out  1  high with the final grayWord of the frame.
- busy  out  1  state is not IDLE.
- frameDone  out  1  one-cycle pulse, asserted the cycle after the last word is accepted.

Behaviour:
- Reset (nReset=0 at an edge): state IDLE, word counter 0, pixelReady 0, grayValid 0, grayWord 0, grayLast 0, busy 0, frameDone 0. Reset mid-frame drops all partial and held data.
- Two converter instances operate on pixelWord[15:0] and pixelWord[31:16] combinationally. Their results are registered into a 16-bit low-half holding register or into the output register.
- States:
  - IDLE: frameStart && enable -> LOW. frameStart is ignored in every other state.
  - LOW: pixelReady=1. On accept, store both gray bytes in the holding register -> HIGH.
  - HIGH: pixelReady = !grayValid || grayReady. On accept, load grayWord = {gray1, gray0, held[15:8], held[7:0]}, set grayValid, increment the word counter, and set grayLast if counter == LINE_PIXELS*LINE_COUNT/4 - 1.
    - If that word is the last one -> DRAIN, otherwise -> LOW.
  - DRAIN: pixelReady=0. When grayValid && grayReady, clear grayValid and grayLast, pulse frameDone, clear the counter -> IDLE.
- Output register:
  - grayValid clears on grayValid && grayReady unless reloaded in the same cycle; simultaneous load and accept keeps grayValid=1 with the new data.
  - grayWord, grayValid and grayLast are stable while grayValid && !grayReady.
- Throughput: one input word per cycle sustained with grayReady=1; latency is one cycle from the second input accept to grayValid.
- Counter width: $clog2(LINE_PIXELS*LINE_COUNT/4); it never wraps because DRAIN clears it.
- enable is sampled only in IDLE; deasserting it mid-frame does not abort the frame.
- busy = (state != IDLE).

Optional Feature:
- Macro: GRAYSCALE_THRESHOLD_EN.
- Defined: adds input port threshold [7:0]. Each output byte is 8'hFF if gray >= threshold, else 8'h00. Comparison is applied before packing and timing is unchanged.
- Undefined: no threshold port; raw grayscale bytes are output.

Test Plan (LINE_PIXELS=8, LINE_COUNT=2, i.e. 4 output words per frame):
- Reset, then frameStart with enable=1, grayReady=1, words 0x00F80000 then 0x1F00E007 -> grayWord=0x13B73600 (bytes 0, 54, 183, 19) one cycle after the second accept, grayLast=0.
- Full frame of eight 0xFFFFFFFF words back-to-back with grayReady=1 -> four 0xFFFFFFFF outputs, grayLast on the 4th only, frameDone pulse one cycle after its accept, busy then 0.
- grayReady held 0 for 5 cycles after the first output -> pixelReady=0 in HIGH, grayWord stable; on release, the next word is accepted in the same cycle the held word leaves (no bubble).
- frameStart pulsed mid-frame, and frameStart with enable=0 in IDLE -> both ignored, counter and state unaffected.
- nReset low after 3 input words -> all outputs 0, state IDLE; a new frame produces correct output from word 0.
- With GRAYSCALE_THRESHOLD_EN and threshold=100: pixels giving 54, 183, 19, 255 -> grayWord=0xFF00FF00.
